// File: rtl/uart_tx.sv
// uart_tx: LSB-first UART transmitter, start/data/[parity]/stop, registered outputs.
// Ports: clk, reset (sync, active-high), tx_start, data_in -> tx, tx_done, busy. Option: UART_TX_PARITY_EN.
module uart_tx #(
  parameter int LEN_DATA     = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tx_start,
  input  logic [LEN_DATA-1:0] data_in,
  output logic                tx,
  output logic                tx_done,
  output logic                busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = (LEN_DATA > 1) ? $clog2(LEN_DATA) : 1;

  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PRE = CW'(CLKS_PER_BIT - 2);
  localparam logic [IW-1:0] IDX_MAX = IW'(LEN_DATA - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t              state, state_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [IW-1:0]       idx, idx_n, idx_inc;
  logic [LEN_DATA-1:0] shreg, shreg_n;
  logic                tx_n, done_n, busy_n;
  logic                bit_end;

  assign bit_end = (cnt == CNT_MAX);
  assign idx_inc = idx + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
      tx_done <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      shreg   <= shreg_n;
      tx      <= tx_n;
      tx_done <= done_n;
      busy    <= busy_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    tx_n    = tx;
    done_n  = 1'b0;
    busy_n  = busy;
    unique case (state)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        cnt_n  = '0;
        idx_n  = '0;
        if (tx_start) begin
          shreg_n = data_in;
          state_n = START;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = DATA;
          tx_n    = shreg[0];
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n = '0;
          if (idx == IDX_MAX) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
            tx_n    = ^shreg;
`else
            state_n = STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            idx_n = idx_inc;
            tx_n  = shreg[idx_inc];
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          cnt_n   = '0;
          state_n = STOP;
          tx_n    = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          cnt_n = '0;
          idx_n = '0;
          // A request in the tx_done cycle chains straight into the next start bit.
          if (tx_start) begin
            shreg_n = data_in;
            state_n = START;
            tx_n    = 1'b0;
            busy_n  = 1'b1;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
            busy_n  = 1'b0;
          end
        end else begin
          cnt_n  = cnt + 1'b1;
          // Registered pulse: raise it on the edge that enters the final stop cycle.
          done_n = (cnt == CNT_PRE);
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized scoreboard bench for uart_tx (CLKS_PER_BIT=4, LEN_DATA=8).
// Stimulus predicts accepted frames; an independent line monitor decodes tx and compares.
module tb_uart_tx;

  localparam int CPB = 4;
  localparam int LEN = 8;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB    = LEN + 2 + PAR;
  localparam int FRAME = NB * CPB;

  typedef struct {
    logic [LEN-1:0] d;
    int             e;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           tx_start = 1'b0;
  logic [LEN-1:0] data_in = '0;
  logic           tx, tx_done, busy;

  exp_t q[$];
  int   edge_n = 0;
  int   free_edge = 0;
  int   checks = 0;
  int   failures = 0;
  bit   abort = 1'b0;
  bit   mon_en = 1'b0;
  bit   mon_busy = 1'b0;

  uart_tx #(.LEN_DATA(LEN), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .tx_start(tx_start), .data_in(data_in),
    .tx(tx), .tx_done(tx_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // One clock of stimulus; the model decides acceptance from frame timing alone.
  task automatic drive(input bit st, input logic [LEN-1:0] d, input bit rst);
    exp_t it;
    tx_start = st;
    data_in  = d;
    reset    = rst;
    @(posedge clk);
    edge_n++;
    if (rst) begin
      free_edge = edge_n + 1;
      q.delete();
      abort = 1'b1;
    end else if (st && edge_n >= free_edge) begin
      it.d = d;
      it.e = edge_n;
      q.push_back(it);
      free_edge = edge_n + FRAME;
    end
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || mon_busy || edge_n <= free_edge) && n < 5000) begin
      drive(1'b0, LEN'($urandom), 1'b0);
      n++;
    end
    chk(n < 5000, "idle_timeout", n, 5000);
    repeat (2) drive(1'b0, '0, 1'b0);
  endtask

  task automatic mon_frame();
    exp_t it;
    logic exp_bit;
    int   berr, busy_err, done_err;
    if (q.size() == 0) begin
      chk(1'b0, "spurious_frame", 1, 0);
      return;
    end
    it = q.pop_front();
    chk(edge_n == it.e, "start_latency", edge_n, it.e);
    busy_err = 0;
    done_err = 0;
    for (int b = 0; b < NB; b++) begin
      if (b == 0)              exp_bit = 1'b0;
      else if (b <= LEN)       exp_bit = it.d[b-1];
      else if (b == NB - 1)    exp_bit = 1'b1;
      else                     exp_bit = ^it.d;
      berr = 0;
      for (int c = 0; c < CPB; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (abort) begin
          abort = 1'b0;
          chk(tx === 1'b1 && busy === 1'b0 && tx_done === 1'b0, "abort_out",
              {tx, busy, tx_done}, 3'b100);
          return;
        end
        if (tx !== exp_bit) berr++;
        if (busy !== 1'b1) busy_err++;
        if (tx_done !== (b == NB - 1 && c == CPB - 1)) done_err++;
      end
      chk(berr == 0, $sformatf("bit%0d_d%02h", b, it.d), berr, 0);
    end
    chk(busy_err == 0, "busy_in_frame", busy_err, 0);
    chk(done_err == 0, "tx_done_pulse", done_err, 0);
  endtask

  initial begin
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (abort) begin
        abort = 1'b0;
        chk(tx === 1'b1 && busy === 1'b0 && tx_done === 1'b0, "reset_out",
            {tx, busy, tx_done}, 3'b100);
      end else if (tx === 1'b0) begin
        mon_busy = 1'b1;
        mon_frame();
        mon_busy = 1'b0;
      end else begin
        chk(tx === 1'b1 && busy === 1'b0 && tx_done === 1'b0, "idle_out",
            {tx, busy, tx_done}, 3'b100);
      end
    end
  end

  initial begin
    logic [LEN-1:0] bb [3];
    int gap, hold;
    bb[0] = 8'hA1; bb[1] = 8'hB2; bb[2] = 8'hC3;

    repeat (3) drive(1'b0, '0, 1'b1);
    mon_en = 1'b1;
    repeat (2) drive(1'b0, '0, 1'b0);

    drive(1'b1, 8'h55, 1'b0);
    wait_idle();
    drive(1'b1, 8'h07, 1'b0);
    wait_idle();

    for (int k = 0; k < 3; k++)
      repeat (FRAME) drive(1'b1, bb[k], 1'b0);
    drive(1'b0, '0, 1'b0);
    wait_idle();

    drive(1'b1, 8'h3C, 1'b0);
    repeat (FRAME - 2) drive(1'($urandom), LEN'($urandom), 1'b0);
    wait_idle();

    drive(1'b1, 8'h96, 1'b0);
    repeat (14) drive(1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b1);
    drive(1'b1, 8'h81, 1'b0);
    wait_idle();

    drive(1'b1, 8'h5A, 1'b1);
    drive(1'b0, '0, 1'b0);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 12) == 0) begin
        drive(1'b0, '0, 1'b1);
      end else begin
        hold = $urandom_range(1, 3);
        repeat (hold) drive(1'b1, LEN'($urandom), 1'b0);
      end
      gap = $urandom_range(0, 50);
      repeat (gap) drive($urandom_range(0, 7) == 0, LEN'($urandom), 1'b0);
    end
    wait_idle();

    chk(q.size() == 0, "queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter LEN_DATA, default 8, giving payload bits per frame.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 868, giving clk cycles per serial bit (115200 baud at 100 MHz); legal values are 2 and above.
REQ-003 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port tx_start, input, 1 bit: request to send data_in.
REQ-006 The block SHALL have port data_in, input, LEN_DATA bits: payload byte from the debug unit.
REQ-007 The block SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-008 The block SHALL have port tx_done, output, 1 bit: one-cycle pulse at the end of a frame.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a frame is in progress.

Function
REQ-010 The FSM SHALL have states IDLE, START, DATA, PARITY (macro-dependent) and STOP, with all outputs registered.
REQ-011 In IDLE, tx SHALL be 1 and busy SHALL be 0; tx_start=1 SHALL latch data_in into an internal shift register and move to START on the same edge.
REQ-012 START SHALL drive tx=0 for exactly CLKS_PER_BIT cycles and then enter DATA.
REQ-013 DATA SHALL drive LEN_DATA bits, LSB first, each for exactly CLKS_PER_BIT cycles, using a bit index that runs 0..LEN_DATA-1.
REQ-014 After the last data bit, DATA SHALL go to PARITY when it is compiled in, and to STOP otherwise.
REQ-015 STOP SHALL drive tx=1 for exactly CLKS_PER_BIT cycles.
REQ-016 tx_done SHALL be 1 only in the final cycle of STOP; the next state SHALL be IDLE.
REQ-017 The baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1, and clear on every bit boundary.
REQ-018 busy SHALL be 1 from the cycle after tx_start is accepted through the tx_done cycle, inclusive.
REQ-019 tx_start asserted while busy=1 SHALL be ignored, and data_in changes while busy=1 SHALL not affect the frame.
REQ-020 tx_start asserted in the tx_done cycle SHALL be accepted (back-to-back): latch data_in, go directly to START, and keep busy=1 with no idle-high gap beyond the stop bit.
REQ-021 Latency from accepted tx_start to the first tx=0 SHALL be 1 cycle.
REQ-022 Frame length SHALL be (LEN_DATA+2)*CLKS_PER_BIT cycles, or (LEN_DATA+3)*CLKS_PER_BIT with parity.

Reset
REQ-023 On reset=1 at a clk edge, the block SHALL set tx=1, busy=0, tx_done=0, state=IDLE, and the baud counter, bit index and shift register to 0.
REQ-024 Reset mid-frame SHALL abandon the frame: tx=1 on the next cycle, no tx_done, and the next tx_start is accepted normally.
REQ-025 Reset SHALL take priority over tx_start in the same cycle.

Configuration
REQ-026 With macro UART_TX_PARITY_EN defined, the PARITY state SHALL send one even-parity bit (XOR of the latched payload) for CLKS_PER_BIT cycles between DATA and STOP.
REQ-027 Without UART_TX_PARITY_EN, the PARITY state and its logic SHALL be absent and frames SHALL be 8N1.

Verification (CLKS_PER_BIT=4, LEN_DATA=8)
REQ-028 A tx_start pulse with data_in=0x55, no parity, SHALL give tx per 4-cycle bit of 0,1,0,1,0,1,0,1,0,1, with tx_done high on cycle 40 after acceptance and busy low on cycle 41.
REQ-029 data_in=0x07 with UART_TX_PARITY_EN SHALL give data bits 1,1,1,0,0,0,0,0, parity 1, stop 1, and a 44-cycle frame; data_in=0x55 SHALL give parity 0.
REQ-030 tx_start held high for 3 frames with data 0xA1, 0xB2, 0xC3 changing only at tx_done SHALL send 3 contiguous frames with no extra idle cycles and 3 tx_done pulses.
REQ-031 tx_start pulses and data_in toggling during DATA of a 0x3C frame SHALL leave the frame bits exactly 0x3C and start no second frame.
REQ-032 Reset asserted on cycle 15 of a frame SHALL give tx=1 on the following cycle, no tx_done, and busy=0; a new tx_start with 0x81 SHALL then produce a correct frame.
